// File: rtl/vm_round_robin_sel.sv
// Four-channel round-robin arbiter producing the 2-bit select for a 2-to-4 decoder.
// A grant is held while its request stays high, bounded by MAX_HOLD cycles.
module vm_round_robin_sel #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic req0,
   input  logic req1,
   input  logic req2,
   input  logic req3,
   output logic sel0,
   output logic sel1,
   output logic valid,
   output logic preempt
);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(MAX_HOLD - 1);

   state_t     state_q, state_d;
   logic [1:0] cur_q, cur_d;
   logic [1:0] ptr_q, ptr_d;
   logic [7:0] cnt_q, cnt_d;
   logic       preempt_q, preempt_d;

   logic [3:0] req;
   logic       pick_valid;
   logic [1:0] pick_idx;
   logic [1:0] scan_idx;

   assign req = {req3, req2, req1, req0};

   // First requester scanning ptr, ptr+1, ... with natural 2-bit wrap.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = ptr_q;
      scan_idx   = ptr_q;
      for (int unsigned i = 0; i < 4; i++) begin
         scan_idx = ptr_q + 2'(i);
         if (!pick_valid && req[scan_idx]) begin
            pick_valid = 1'b1;
            pick_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      preempt_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (en && pick_valid) begin
               state_d = GRANT;
               cur_d   = pick_idx;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            if (!en || !req[cur_q] || (cnt_q == CNT_LAST)) begin
               state_d   = IDLE;
               ptr_d     = cur_q + 2'd1;
               // Only a timeout with enable and request still high counts as preemption.
               preempt_d = en && req[cur_q];
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cur_q     <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         preempt_q <= preempt_d;
      end
   end

   assign sel0    = cur_q[0];
   assign sel1    = cur_q[1];
   assign valid   = (state_q == GRANT);
   assign preempt = preempt_q;

endmodule
